// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths used by the pipeline output side.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int WPB     = BLOCK_W / WORD_W;
  localparam int IDX_W   = $clog2(WPB);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [IDX_W-1:0]   word_idx_t;

  // Word 0 is the most-significant slice of the block.
  function automatic word_t block_word(block_t blk, word_idx_t idx);
    return blk[BLOCK_W-1-int'(idx)*WORD_W -: WORD_W];
  endfunction

endpackage

// File: rtl/aes_output_serializer_if.sv
// Bundle between the AES pipeline, the output serializer and its downstream word consumer.
interface aes_output_serializer_if #(
  parameter int DEPTH = 4
);
  import aes_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  block_t           in_block;
  logic             out_valid;
  logic             out_ready;
  word_t            out_word;
  logic             out_last;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             overflow_clear;

  modport master (
    input  in_valid, in_block, out_ready, overflow_clear,
    output out_valid, out_word, out_last, count, overflow
  );

  modport slave (
    output in_valid, in_block, out_ready, overflow_clear,
    input  out_valid, out_word, out_last, count, overflow
  );

endinterface

// File: rtl/aes_block_fifo.sv
// Block FIFO holding whole 128-bit AES results; full/empty come from the count, not pointer equality.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  block_t           wdata,
  output block_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  block_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // The pipeline cannot stall, so a full FIFO still takes a block when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/aes_output_serializer.sv
// Captures non-stallable AES result blocks and streams them out as 32-bit words, MS word first.
module aes_output_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                     clock,
  input logic                     reset,
  aes_output_serializer_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  block_t           head_block;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  word_idx_t        idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic             head_valid;
  logic             is_last;
  logic             xfer;
  logic             pop;

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_block),
    .rdata (head_block),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign head_valid = !fifo_empty;
  assign is_last    = head_valid && (idx_q == word_idx_t'(WPB - 1));
  assign xfer       = head_valid && bus.out_ready;
  assign pop        = xfer && is_last;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (xfer) idx_d = is_last ? '0 : idx_q + word_idx_t'(1);
    if (bus.overflow_clear)     overflow_d = 1'b0;
    if (fifo_drop && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_word  = head_valid ? block_word(head_block, idx_q) : '0;
  assign bus.out_last  = is_last;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_aes_output_serializer.sv
// Self-checking bench for aes_output_serializer against a queue-of-blocks reference model.
module tb_aes_output_serializer;
  import aes_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam block_t SPEC_BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clock = 1'b0;
  logic reset;

  aes_output_serializer_if #(.DEPTH(DEPTH)) bus ();

  aes_output_serializer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: stored blocks in arrival order, word position in the head block, sticky flag.
  block_t mq[$];
  int     widx;
  bit     movf;

  function automatic word_t word_of(block_t b, int k);
    return word_t'(b >> (WORD_W * (WPB - 1 - k)));
  endfunction

  function automatic bit m_valid();
    return mq.size() != 0;
  endfunction

  function automatic bit m_last();
    return (mq.size() != 0) && (widx == WPB - 1);
  endfunction

  function automatic word_t m_word();
    if (mq.size() == 0) return '0;
    return word_of(mq[0], widx);
  endfunction

  function automatic logic [CNT_W+34:0] m_outs();
    return {m_valid(), m_last(), movf, CNT_W'(mq.size()), m_word()};
  endfunction

  function automatic logic [CNT_W+34:0] dut_outs();
    return {bus.out_valid, bus.out_last, bus.overflow, bus.count, bus.out_word};
  endfunction

  function automatic block_t rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    widx = 0;
    movf = 1'b0;
  endtask

  // Drives one cycle of inputs from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic tick(input bit v, input block_t blk, input bit rdy, input bit clr);
    bit     xfer, popb, pushb;
    block_t gone;
    bus.in_valid       = v;
    bus.in_block       = blk;
    bus.out_ready      = rdy;
    bus.overflow_clear = clr;
    @(posedge clock);
    xfer  = m_valid() && rdy;
    popb  = xfer && (widx == WPB - 1);
    pushb = v && ((mq.size() < DEPTH) || popb);
    if (popb) begin
      gone = mq.pop_front();
      widx = 0;
    end else if (xfer) begin
      widx++;
    end
    if (pushb) mq.push_back(blk);
    if (v && !pushb) movf = 1'b1;
    else if (clr)    movf = 1'b0;
    @(negedge clock);
    bus.in_valid       = 1'b0;
    bus.overflow_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_block       = '0;
    bus.out_ready      = 1'b0;
    bus.overflow_clear = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_word !== '0) begin errors++; $display("[TB] FAIL reset_word: got %h expected 0", bus.out_word); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", bus.out_last); end
    checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_single();
    word_t exp_w [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [CNT_W+33:0] got, exp;
    tick(1'b1, SPEC_BLK, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = {bus.out_valid, bus.out_last, bus.count, bus.out_word};
      exp = {1'b1, (i == 3), CNT_W'(1), exp_w[i]};
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL single_word%0d: got %h expected %h", i, got, exp); end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.count !== '0) begin errors++; $display("[TB] FAIL single_empty: got valid=%b count=%0d expected valid=0 count=0", bus.out_valid, bus.count); end
  endtask

  task automatic test_backpressure();
    tick(1'b1, SPEC_BLK, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h00112233 || bus.out_last !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got valid=%b word=%h last=%b expected valid=1 word=00112233 last=0", i, bus.out_valid, bus.out_word, bus.out_last);
      end
      if (i < 5) tick(1'b0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_word !== word_of(SPEC_BLK, i)) begin errors++; $display("[TB] FAIL stall_release%0d: got %h expected %h", i, bus.out_word, word_of(SPEC_BLK, i)); end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_fill_overflow();
    block_t blks [5];
    for (int i = 0; i < 5; i++) blks[i] = rand_block();
    for (int i = 0; i < 4; i++) tick(1'b1, blks[i], 1'b0, 1'b0);
    checks++; if (bus.count !== CNT_W'(4) || bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got count=%0d ovf=%b expected count=4 ovf=0", bus.count, bus.overflow); end
    tick(1'b1, blks[4], 1'b0, 1'b0);
    checks++; if (bus.count !== CNT_W'(4) || bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_drop: got count=%0d ovf=%b expected count=4 ovf=1", bus.count, bus.overflow); end
    for (int w = 0; w < 16; w++) begin
      checks++; if (bus.out_word !== word_of(blks[w / 4], w % 4) || dut_outs() !== m_outs()) begin
        errors++; $display("[TB] FAIL fill_drain%0d: got %h expected %h", w, dut_outs(), m_outs());
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.count !== '0 || bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_sticky: got count=%0d ovf=%b expected count=0 ovf=1", bus.count, bus.overflow); end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_clear: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    block_t blks [5];
    for (int i = 0; i < 5; i++) blks[i] = rand_block();
    for (int i = 0; i < 4; i++) tick(1'b1, blks[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.out_last !== 1'b1 || bus.count !== CNT_W'(4)) begin errors++; $display("[TB] FAIL fullpop_setup: got last=%b count=%0d expected last=1 count=4", bus.out_last, bus.count); end
    tick(1'b1, blks[4], 1'b1, 1'b0);
    checks++; if (bus.count !== CNT_W'(4) || bus.overflow !== 1'b0 || bus.out_word !== word_of(blks[1], 0)) begin
      errors++; $display("[TB] FAIL fullpop_accept: got count=%0d ovf=%b word=%h expected count=4 ovf=0 word=%h", bus.count, bus.overflow, bus.out_word, word_of(blks[1], 0));
    end
    for (int w = 0; w < 16; w++) begin
      checks++; if (bus.out_word !== word_of(blks[1 + w / 4], w % 4) || dut_outs() !== m_outs()) begin
        errors++; $display("[TB] FAIL fullpop_drain%0d: got %h expected %h", w, dut_outs(), m_outs());
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 4; i++) tick(1'b1, rand_block(), 1'b0, 1'b0);
    tick(1'b1, rand_block(), 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_set_wins: got %b expected 1", bus.overflow); end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_after: got %b expected 0", bus.overflow); end
    for (int w = 0; w < 16; w++) begin
      checks++; if (dut_outs() !== m_outs()) begin errors++; $display("[TB] FAIL clr_drain%0d: got %h expected %h", w, dut_outs(), m_outs()); end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    word_t  exp_words[$];
    word_t  w;
    block_t blk;
    int     got_words = 0;
    int     maxc = 0;
    for (int cyc = 0; cyc < 44; cyc++) begin
      checks++; if (dut_outs() !== m_outs()) begin errors++; $display("[TB] FAIL wrap_cycle%0d: got %h expected %h", cyc, dut_outs(), m_outs()); end
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_words.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_extra: got word %h expected none", bus.out_word);
        end else begin
          w = exp_words.pop_front();
          got_words++;
          if (bus.out_word !== w) begin errors++; $display("[TB] FAIL wrap_word%0d: got %h expected %h", got_words, bus.out_word, w); end
        end
      end
      blk = rand_block();
      if (cyc < 40 && cyc % 4 == 0) begin
        for (int k = 0; k < WPB; k++) exp_words.push_back(word_of(blk, k));
        tick(1'b1, blk, 1'b1, 1'b0);
      end else begin
        tick(1'b0, '0, 1'b1, 1'b0);
      end
    end
    checks++; if (got_words != 40) begin errors++; $display("[TB] FAIL wrap_total: got %0d words expected 40", got_words); end
    checks++; if (maxc > 2) begin errors++; $display("[TB] FAIL wrap_maxcount: got %0d expected at most 2", maxc); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_random();
    bit v, rdy, clr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (dut_outs() !== m_outs()) begin errors++; $display("[TB] FAIL random_cycle%0d: got %h expected %h", cyc, dut_outs(), m_outs()); end
      v   = ($urandom_range(0, 99) < 40);
      rdy = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 5);
      tick(v, rand_block(), rdy, clr);
    end
  endtask

  task automatic test_reset_midstream();
    block_t b1, b2, b3;
    for (int i = 0; i < 40 && m_valid(); i++) tick(1'b0, '0, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre_drain: got valid=%b ovf=%b expected 0 0", bus.out_valid, bus.overflow); end
    b1 = rand_block();
    b2 = rand_block();
    b3 = rand_block();
    tick(1'b1, b1, 1'b0, 1'b0);
    tick(1'b1, b2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.count !== CNT_W'(1) || bus.out_word !== word_of(b2, 2)) begin
      errors++; $display("[TB] FAIL mid_position: got count=%0d word=%h expected count=1 word=%h", bus.count, bus.out_word, word_of(b2, 2));
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out_last, bus.out_word} !== '0 || bus.count !== '0 || bus.overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_async_clear: got valid=%b last=%b word=%h count=%0d ovf=%b expected all 0", bus.out_valid, bus.out_last, bus.out_word, bus.count, bus.overflow);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    tick(1'b1, b3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_word !== word_of(b3, k) || dut_outs() !== m_outs()) begin
        errors++; $display("[TB] FAIL mid_restream%0d: got %h expected %h", k, dut_outs(), m_outs());
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_final_empty: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_fill_overflow();
    test_full_pop();
    test_clear_priority();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_output_serializer.md
Name: aes_output_serializer

Overview:
Output-side consumer for the AES pipeline stages. The pipeline registers deliver one 128-bit result block per valid cycle and cannot be stalled. This block captures those blocks into a small block FIFO. It streams each block out as 32-bit words over a valid/ready handshake, most-significant word first. Overflow is flagged when the pipeline delivers a block that cannot be stored.

Parameters:
DEPTH, 4, number of 128-bit blocks stored; power of 2, at least 2
BLOCK_W, 128, block width in bits
WORD_W, 32, output word width; BLOCK_W/WORD_W = WPB = 4 words per block

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low; asserting clears all state immediately, deassertion is synchronous to clock
in_valid  input  1  pipeline result valid this cycle; no backpressure
in_block  input  BLOCK_W  result block; sampled when in_valid=1
out_valid  output  1  out_word holds a valid word
out_ready  input  1  downstream accepts out_word this cycle
out_word  output  WORD_W  current word of the head block
out_last  output  1  out_word is the final word (index WPB-1) of its block
count  output  $clog2(DEPTH)+1  number of blocks stored, including a partially sent head block
overflow  output  1  sticky; a block was dropped
overflow_clear  input  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0; read and write pointers=0; word index=0.
  - overflow=0; out_valid=0; out_word=0; out_last=0.
  - Any stored or partially sent blocks are discarded.
  - Storage contents need not be cleared.
- Handshake:
  - A word transfers on a posedge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_word and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Output decode:
  - out_valid = (count != 0).
  - out_word = head block bits [BLOCK_W-1-idx*WORD_W -: WORD_W], where idx is the word index. Word 0 is bits 127:96.
  - out_word = 0 when count=0.
  - out_last = out_valid and (idx == WPB-1).
- Word index:
  - Increments on each transfer.
  - On a transfer with out_last=1: index wraps to 0, the head block pops, and the read pointer advances modulo DEPTH.
- Latency: a block pushed at posedge t presents word 0 with out_valid=1 immediately after t, provided the FIFO was empty. The read is combinational from storage at the head pointer.
- Push:
  - Condition: in_valid=1 and (count < DEPTH or pop this cycle).
  - A pop this cycle means a transfer with out_last=1.
  - On push: write in_block at the write pointer; the write pointer advances modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with simultaneous pop: the incoming block is accepted and no overflow is raised.
- Full without pop: in_valid=1 drops the block. Storage, pointers and count are unchanged; overflow is set to 1 at that edge.
- overflow_clear:
  - Clears overflow at the posedge.
  - If a drop occurs in the same cycle, set wins and overflow stays 1.
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Full versus empty is distinguished by count, not by pointer equality.
- Partial block: the head block is not popped until all WPB words have transferred. A half-sent block still counts as 1.

Decomposition:
- Shared package aes_pkg holds:
  - typedefs block_t (logic [127:0]) and word_t (logic [31:0]);
  - constants BLOCK_W, WORD_W, WPB.
  The pipeline Buffer instances use block_t as their type parameter.
- One sub-module, aes_block_fifo:
  - DEPTH-entry block_t storage, pointers, count, full/empty, and the push-with-pop-when-full rule.
  - Ports: push, pop, wdata, rdata (head), count, full, empty, drop.
- aes_output_serializer contains the word index, out_word mux, handshake logic and overflow register.

Test Plan:
1. Single block 0x00112233_44556677_8899AABB_CCDDEEFF with out_ready=1 held:
   - out_word sequence 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles.
   - out_last=1 only on CCDDEEFF; count 1→0; out_valid=0 afterwards.
2. Backpressure: push one block, hold out_ready=0 for 5 cycles.
   - out_word stays 00112233 and out_valid stays 1.
   - Then out_ready=1 completes all 4 words in order.
3. Fill to full: out_ready=0, push 4 blocks, then push a 5th.
   - count=4; the 5th block is dropped; overflow=1.
   - Draining yields exactly blocks 1–4.
   - overflow_clear=1 returns overflow to 0.
4. Full with simultaneous pop:
   - count=4, head at word 3, out_ready=1, in_valid=1 in the same cycle.
   - Block accepted; count stays 4; overflow stays 0.
   - Drain order is preserved.
5. Pointer wrap: stream 10 blocks at one push per 4 cycles with out_ready=1.
   - All 40 words arrive in order; overflow=0; count never exceeds 2.
6. Reset mid-stream: assert reset=0 after word 1 of block 2, between clock edges.
   - Outputs go to 0 immediately; count=0.
   - After deassertion, a new block streams from word 0 correctly.
